// File: rtl/work_transmit.sv
// 8N1 UART transmitter for one 512-bit work unit {midstate, data2}, sent as 64 bytes
// with byte 0 = data2[7:0] first. Stop and start bits are back to back; there is no idle gap.
module work_transmit #(
   parameter int unsigned BAUD_DIV = 1000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         send,
   input  logic [255:0] midstate,
   input  logic [255:0] data2,
   output logic         TxD,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   localparam logic [15:0] DIV_LAST = 16'(BAUD_DIV - 1);

   state_t       state_q, state_d;
   logic [15:0]  div_cnt_q, div_cnt_d;
   logic [2:0]   bit_cnt_q, bit_cnt_d;
   logic [5:0]   byte_cnt_q, byte_cnt_d;
   logic [511:0] word_q, word_d;
   logic         txd_q, txd_d;
   logic         done_q, done_d;
   logic         bit_end;

   assign bit_end = (div_cnt_q == DIV_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         div_cnt_q  <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         word_q     <= '0;
         txd_q      <= 1'b1;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         div_cnt_q  <= div_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         byte_cnt_q <= byte_cnt_d;
         word_q     <= word_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      div_cnt_d  = bit_end ? 16'd0 : div_cnt_q + 16'd1;
      bit_cnt_d  = bit_cnt_q;
      byte_cnt_d = byte_cnt_q;
      word_d     = word_q;
      case (state_q)
         IDLE: begin
            div_cnt_d = '0;
            if (send) begin
               state_d    = START;
               word_d     = {midstate, data2};
               bit_cnt_d  = '0;
               byte_cnt_d = '0;
            end
         end
         START: if (bit_end) begin
            state_d   = DATA;
            bit_cnt_d = '0;
         end
         DATA: if (bit_end) begin
            if (bit_cnt_q == 3'd7) state_d = STOP;
            else                   bit_cnt_d = bit_cnt_q + 3'd1;
         end
         STOP: if (bit_end) begin
            word_d = word_q >> 8;
            if (byte_cnt_q == 6'd63) begin
               state_d    = IDLE;
               byte_cnt_d = '0;
            end else begin
               state_d    = START;
               byte_cnt_d = byte_cnt_q + 6'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // TxD is registered from the next state, so the line level changes on the same edge as the state.
   always_comb begin
      txd_d  = 1'b1;
      done_d = (state_q == STOP) && bit_end && (byte_cnt_q == 6'd63);
      case (state_d)
         START:   txd_d = 1'b0;
         DATA:    txd_d = word_d[bit_cnt_d];
         default: txd_d = 1'b1;
      endcase
   end

   assign TxD  = txd_q;
   assign busy = (state_q != IDLE);
   assign done = done_q;

endmodule

// File: tb/tb_work_transmit.sv
// Directed bench for work_transmit at BAUD_DIV=4. The line is logged once per cycle,
// and bytes are decoded by sampling the middle of each bit.
module tb_work_transmit;
   localparam int B    = 4;
   localparam int UNIT = 640 * B;

   logic         clk = 1'b0;
   logic         reset, send;
   logic [255:0] midstate, data2;
   logic         TxD, busy, done;

   logic         txd_log [0:UNIT+63];
   int           done_cnt, done_pos, busy_cnt;
   int           total = 0, passed = 0;

   logic [255:0] ms, d2, ms_b, d2_b;
   logic [511:0] got;
   int           ferr, ones;
   logic [39:0]  obs40, exp40;
   logic [9:0]   fr;

   work_transmit #(.BAUD_DIV(B)) dut (
      .clk(clk), .reset(reset), .send(send), .midstate(midstate), .data2(data2),
      .TxD(TxD), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // Called at a negedge. It leaves the bench at the negedge after the accept edge (t=0).
   task automatic start_unit(input logic [255:0] m, input logic [255:0] d);
      send = 1'b1; midstate = m; data2 = d;
      @(negedge clk);
      send = 1'b0; midstate = ~m; data2 = ~d;
   endtask

   // Logs n cycles. It optionally raises send for one cycle at t == inj_t.
   task automatic capture(input int n, input int inj_t, input logic [255:0] im, input logic [255:0] id);
      done_cnt = 0; done_pos = -1; busy_cnt = 0;
      for (int t = 0; t < n; t++) begin
         txd_log[t] = TxD;
         if (done) begin
            done_cnt++;
            if (done_pos < 0) done_pos = t;
         end
         if (busy) busy_cnt++;
         if (t == inj_t) begin
            send = 1'b1; midstate = im; data2 = id;
         end else send = 1'b0;
         @(negedge clk);
      end
      send = 1'b0;
   endtask

   task automatic decode(output logic [511:0] w, output int fe);
      int base;
      w = '0; fe = 0;
      for (int k = 0; k < 64; k++) begin
         base = 10 * B * k;
         if (txd_log[base + B/2] !== 1'b0) fe++;
         for (int b = 0; b < 8; b++) w[8*k + b] = txd_log[base + B*(b+1) + B/2];
         if (txd_log[base + 9*B + B/2] !== 1'b1) fe++;
      end
   endtask

   initial begin
      reset = 1'b1; send = 1'b0; midstate = '0; data2 = '0;
      repeat (3) @(negedge clk);
      check("rst_txd", TxD, 1); check("rst_busy", busy, 0); check("rst_done", done, 0);
      reset = 1'b0;
      @(negedge clk);

      // 1: single unit, byte k = k
      for (int i = 0; i < 32; i++) begin
         d2[8*i +: 8] = 8'(i);
         ms[8*i +: 8] = 8'(i + 32);
      end
      start_unit(ms, d2);
      capture(UNIT + 1, -1, '0, '0);
      check("t1_start", txd_log[0], 0);
      check("t1_busy_cycles", busy_cnt, UNIT);
      check("t1_done_cnt", done_cnt, 1);
      check("t1_done_pos", done_pos, UNIT);
      check("t1_idle_txd", txd_log[UNIT], 1);
      decode(got, ferr);
      check("t1_word", got, {ms, d2});
      check("t1_framing", ferr, 0);

      // 2: framing and bit timing of 0xA5
      d2 = {248'b0, 8'hA5}; ms = '0;
      start_unit(ms, d2);
      capture(UNIT + 1, -1, '0, '0);
      fr = 10'b1101001010;
      for (int i = 0; i < 40; i++) begin
         obs40[i] = txd_log[i];
         exp40[i] = fr[i / B];
      end
      check("t2_frame_bits", obs40, exp40);
      check("t2_next_start", txd_log[40], 0);
      decode(got, ferr);
      check("t2_word", got, {ms, d2});

      // 3: send while busy is ignored
      ms = {8{32'h01234567}}; d2 = {8{32'hDEADBEEF}};
      start_unit(ms, d2);
      capture(UNIT + 1, 100, {8{32'hCAFEF00D}}, {8{32'h5A5AA5A5}});
      decode(got, ferr);
      check("t3_word", got, {ms, d2});
      check("t3_framing", ferr, 0);
      check("t3_done_cnt", done_cnt, 1);
      check("t3_done_pos", done_pos, UNIT);

      // 4: back-to-back units, with send in the done cycle
      ms   = {8{32'h89ABCDEF}}; d2   = {8{32'h13579BDF}};
      ms_b = {8{32'h0F1E2D3C}}; d2_b = {8{32'hF0E1D2C3}};
      start_unit(ms, d2);
      capture(UNIT + 1, UNIT, ms_b, d2_b);
      check("t4a_done_pos", done_pos, UNIT);
      decode(got, ferr);
      check("t4a_word", got, {ms, d2});
      capture(UNIT + 1, -1, '0, '0);
      check("t4b_start_next", txd_log[0], 0);
      decode(got, ferr);
      check("t4b_word", got, {ms_b, d2_b});
      check("t4b_framing", ferr, 0);
      check("t4b_done_pos", done_pos, UNIT);

      // 5: reset mid-byte (byte 30, data phase)
      ms = {8{32'h2468ACE0}}; d2 = {8{32'h11223344}};
      start_unit(ms, d2);
      capture(1234, -1, '0, '0);
      check("t5_no_early_done", done_cnt, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_txd", TxD, 1); check("t5_busy", busy, 0); check("t5_done", done, 0);
      capture(200, -1, '0, '0);
      check("t5_quiet_done", done_cnt, 0);
      check("t5_quiet_busy", busy_cnt, 0);
      start_unit(ms, d2);
      capture(UNIT + 1, -1, '0, '0);
      decode(got, ferr);
      check("t5_resend_word", got, {ms, d2});
      check("t5_resend_done", done_pos, UNIT);

      // 6: reset and send in the same cycle
      reset = 1'b1; send = 1'b1; midstate = '1; data2 = '0;
      @(negedge clk);
      reset = 1'b0; send = 1'b0;
      check("t6_busy", busy, 0); check("t6_txd", TxD, 1);
      capture(20, -1, '0, '0);
      ones = 0;
      for (int t = 0; t < 20; t++) if (txd_log[t] === 1'b1) ones++;
      check("t6_busy_later", busy_cnt, 0);
      check("t6_txd_high", ones, 20);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
